// File: rtl/systolic_tile_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | systolic_tile_ctrl_if : host-side start/status, A/B row and C row streams   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface systolic_tile_ctrl_if #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
);
    localparam int ROWBITS = $clog2(DIM);

    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   in_valid;
    logic                   in_ready;
    logic [DIM*BITS_AB-1:0] in_A;
    logic [DIM*BITS_AB-1:0] in_B;
    logic                   out_valid;
    logic                   out_ready;
    logic [ROWBITS-1:0]     out_row;
    logic [DIM*BITS_C-1:0]  out_C;

    modport slave (
        input  start, in_valid, in_A, in_B, out_ready,
        output busy, done, in_ready, out_valid, out_row, out_C
    );

    modport master (
        output start, in_valid, in_A, in_B, out_ready,
        input  busy, done, in_ready, out_valid, out_row, out_C
    );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | systolic_tile_ctrl : load A/B rows, flush array, stream C rows, clear C      |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module systolic_tile_ctrl #(
    parameter  int BITS_AB = 8,
    parameter  int BITS_C  = 16,
    parameter  int DIM     = 8,
    localparam int ROWBITS = $clog2(DIM)
) (
    input  wire logic               clk,
    input  wire logic               rst,
    systolic_tile_ctrl_if.slave     host,
    output logic                    en,
    output logic                    WrEnMemA,
    output logic [ROWBITS-1:0]      Arow,
    output logic [DIM*BITS_AB-1:0]  Ain,
    output logic [DIM*BITS_AB-1:0]  Bin,
    output logic                    WrEn,
    output logic [ROWBITS-1:0]      Crow,
    output logic [DIM*BITS_C-1:0]   Cin,
    input  wire logic [DIM*BITS_C-1:0] Cout
);
    localparam int CW = ROWBITS + 2;
    localparam logic [CW-1:0] c_last_row   = CW'(DIM - 1);
    localparam logic [CW-1:0] c_flush_last = CW'(2 * DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RDSET = 3'd3,
        S_RDOUT = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] row_q, row_d;
    logic          done_q, done_d;
    logic          beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        beat    = (state_q == S_LOAD) && host.in_valid;

        case (state_q)
            // done_q marks the first IDLE cycle; a start seen then is deliberately dropped
            S_IDLE: begin
                if (host.start && !done_q) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    if (cnt_q == c_last_row) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == c_flush_last) begin
                    state_d = S_RDSET;
                    cnt_d   = '0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RDSET: state_d = S_RDOUT;
            S_RDOUT: begin
                if (host.out_ready) begin
                    if (row_q == c_last_row) begin
                        state_d = S_CLEAR;
                        row_d   = '0;
                    end else begin
                        state_d = S_RDSET;
                        row_d   = row_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (row_q == c_last_row) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        host.busy      = (state_q != S_IDLE);
        host.done      = done_q;
        host.in_ready  = (state_q == S_LOAD);
        host.out_valid = (state_q == S_RDOUT);
        host.out_row   = row_q[ROWBITS-1:0];
        host.out_C     = Cout;

        // The array only advances on real load beats and during the flush window
        en       = beat || (state_q == S_FLUSH);
        WrEnMemA = beat;
        Arow     = cnt_q[ROWBITS-1:0];
        Ain      = host.in_A;
        Bin      = beat ? host.in_B : '0;
        WrEn     = (state_q == S_CLEAR);
        Crow     = row_q[ROWBITS-1:0];
        Cin      = '0;
    end
endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_systolic_tile_ctrl : directed tiles against a behavioural array model    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_systolic_tile_ctrl;
    localparam int DIM     = 8;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int RB      = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_tile_ctrl_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) h();

    logic                   en, WrEnMemA, WrEn;
    logic [RB-1:0]          Arow, Crow;
    logic [DIM*BITS_AB-1:0] Ain, Bin;
    logic [DIM*BITS_C-1:0]  Cin, Cout;

    systolic_tile_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .host     (h),
        .en       (en),
        .WrEnMemA (WrEnMemA),
        .Arow     (Arow),
        .Ain      (Ain),
        .Bin      (Bin),
        .WrEn     (WrEn),
        .Crow     (Crow),
        .Cin      (Cin),
        .Cout     (Cout)
    );

    // Behavioural memA/memB/array: product is accumulated once 3*DIM enables are seen
    logic signed [BITS_AB-1:0] m_a [DIM][DIM];
    logic signed [BITS_AB-1:0] m_b [DIM][DIM];
    int m_c [DIM][DIM];
    int en_cnt, en_run, max_run, wr_cnt, crow_err;

    function automatic int dot(input int i, input int j);
        int s = 0;
        for (int k = 0; k < DIM; k++) s += int'(m_a[i][k]) * int'(m_b[k][j]);
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    m_a[i][j] <= '0;
                    m_b[i][j] <= '0;
                    m_c[i][j] <= 0;
                end
            en_cnt <= 0; en_run <= 0; max_run <= 0; wr_cnt <= 0; crow_err <= 0;
            Cout   <= '0;
        end else begin
            if (!h.busy) begin
                en_cnt <= 0; en_run <= 0; max_run <= 0; wr_cnt <= 0; crow_err <= 0;
            end else begin
                if (en) begin
                    en_cnt <= en_cnt + 1;
                    en_run <= en_run + 1;
                    if (en_run + 1 > max_run) max_run <= en_run + 1;
                end else begin
                    en_run <= 0;
                end
                if (WrEn) begin
                    if (int'(Crow) != wr_cnt) crow_err <= crow_err + 1;
                    wr_cnt <= wr_cnt + 1;
                end
            end
            if (en && WrEnMemA)
                for (int c = 0; c < DIM; c++) begin
                    m_a[Arow][c] <= Ain[c*BITS_AB +: BITS_AB];
                    m_b[Arow][c] <= Bin[c*BITS_AB +: BITS_AB];
                end
            if (en && en_cnt == 3*DIM - 1)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++)
                        m_c[i][j] <= m_c[i][j] + dot(i, j);
            if (WrEn)
                for (int c = 0; c < DIM; c++)
                    m_c[Crow][c] <= int'($signed(Cin[c*BITS_C +: BITS_C]));
            for (int c = 0; c < DIM; c++)
                Cout[c*BITS_C +: BITS_C] <= BITS_C'(m_c[Crow][c]);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit bubble;
        int stall_row;
        int stall_len;
        bit ident;
        bit hold;
        int exp_lat;
        int exp_run;
    } tile_t;

    tile_t tbl [6];
    int a_s [DIM][DIM];
    int b_s [DIM][DIM];
    int e_s [DIM][DIM];

    function automatic logic [DIM*BITS_AB-1:0] pack_ab(input int m [DIM][DIM], input int r);
        logic [DIM*BITS_AB-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*BITS_AB +: BITS_AB] = BITS_AB'(m[r][c]);
        return v;
    endfunction

    function automatic logic [DIM*BITS_C-1:0] pack_c(input int r);
        logic [DIM*BITS_C-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = BITS_C'(e_s[r][c]);
        return v;
    endfunction

    task automatic abort_test();
        int bad;
        h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        h.in_valid = 1'b1;
        h.in_A = '1;
        h.in_B = '1;
        repeat (DIM) @(negedge clk);
        h.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre_flush", {h.busy, en, h.in_ready}, 3'b110);
        rst = 1'b1;
        #1;
        check("abort_outputs", {h.busy, en, h.done, h.in_ready, h.out_valid, WrEnMemA, WrEn}, '0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (h.done || h.busy) bad++;
        end
        check("abort_quiet", bad, 0);
    endtask

    task automatic run_tile(input tile_t tc);
        int guard, r;
        bit toggle;
        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                a_s[i][k] = tc.ident ? int'(i == k) : int'($urandom_range(0, 255)) - 128;
                b_s[i][k] = int'($urandom_range(0, 255)) - 128;
            end
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                e_s[i][j] = 0;
                for (int k = 0; k < DIM; k++) e_s[i][j] += a_s[i][k] * b_s[k][j];
            end

        h.start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (guard == 1) check("done_width", h.done, 1'b0);
        end while (!h.busy && guard < 10);
        check("start_latency", guard, tc.exp_lat);
        if (!tc.hold) h.start = 1'b0;

        r = 0; toggle = 1'b0; guard = 0;
        while (r < DIM && guard < 40) begin
            if (tc.bubble && toggle) begin
                h.in_valid = 1'b0;
                #1;
                check("bubble_idle", {en, WrEnMemA, Bin}, '0);
            end else begin
                h.in_valid = 1'b1;
                h.in_A = pack_ab(a_s, r);
                h.in_B = pack_ab(b_s, r);
                #1;
                if (h.in_ready) begin
                    check("load_beat", {en, WrEnMemA, Arow, Ain, Bin},
                          {2'b11, RB'(r), pack_ab(a_s, r), pack_ab(b_s, r)});
                    r++;
                end
            end
            toggle = !toggle;
            guard++;
            @(negedge clk);
        end
        h.in_valid = 1'b0;
        check("load_rows", r, DIM);

        for (int row = 0; row < DIM; row++) begin
            h.out_ready = (row != tc.stall_row);
            guard = 0;
            while (!h.out_valid && guard < 60) begin
                @(negedge clk);
                guard++;
            end
            if (row == tc.stall_row)
                for (int s = 0; s < tc.stall_len; s++) begin
                    check("stall_hold", {h.out_valid, h.out_row, h.out_C}, {1'b1, RB'(row), pack_c(row)});
                    @(negedge clk);
                end
            h.out_ready = 1'b1;
            check("c_row", {h.out_valid, h.out_row, h.out_C}, {1'b1, RB'(row), pack_c(row)});
            @(negedge clk);
        end

        guard = 0;
        while (!h.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {h.done, h.busy}, 2'b10);
        check("en_total", en_cnt, 3*DIM);
        check("en_max_run", max_run, tc.exp_run);
        check("clear_rows", {wr_cnt, crow_err}, {32'(DIM), 32'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //          bubble stall len ident hold lat run
        tbl[0] = '{1'b0, -1, 0, 1'b0, 1'b0, 1, 24};
        tbl[1] = '{1'b1, -1, 0, 1'b0, 1'b0, 2, 17};
        tbl[2] = '{1'b0,  3, 5, 1'b0, 1'b0, 2, 24};
        tbl[3] = '{1'b0, -1, 0, 1'b1, 1'b0, 2, 24};
        tbl[4] = '{1'b0, -1, 0, 1'b0, 1'b1, 2, 24};
        tbl[5] = '{1'b1,  6, 2, 1'b1, 1'b1, 2, 17};

        rst = 1'b1;
        h.start = 1'b0;
        h.in_valid = 1'b0;
        h.in_A = '0;
        h.in_B = '0;
        h.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              {h.busy, h.done, h.in_ready, h.out_valid, en, WrEnMemA, WrEn, Arow, Crow, h.out_row}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {h.busy, h.done, h.in_ready}, 3'b000);

        abort_test();
        for (int t = 0; t < 6; t++) run_tile(tbl[t]);
        h.start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
